// File: rtl/bitonic_sorter_seq_if.sv
// Stream bundle for the sequential bitonic sorter: an input word stream, a sorted
// output stream with a last-word marker, and the busy flag.
interface bitonic_sorter_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         sort_desc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  modport slave (
    input  in_valid, in_data, sort_desc, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, sort_desc, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bitonic_sorter_seq.sv
// Sequential bitonic sorter: loads N words, sorts them in place with a single
// compare-exchange unit (one index per cycle), then drains them in order.
module bitonic_sorter_seq #(
  parameter int W      = 32,
  parameter int LOG_N  = 3,
  parameter bit SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst,
  bitonic_sorter_seq_if.slave bus
);
  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] IDX_LAST = LOG_N'(N - 1);
  localparam logic [LOG_N:0]   K_MAX    = (LOG_N + 1)'(N);
  localparam logic [LOG_N:0]   KJ_ONE   = (LOG_N + 1)'(1);
  localparam logic [LOG_N:0]   K_FIRST  = (LOG_N + 1)'(2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LOG_N-1:0] idx_q, idx_d;
  logic [LOG_N-1:0] i_q, i_d;
  logic [LOG_N:0]   k_q, k_d;
  logic [LOG_N:0]   j_q, j_d;
  logic             dir_q, dir_d;
  logic [W-1:0]     mem_q [N];
  logic [W-1:0]     mem_d [N];
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic [LOG_N-1:0] partner_s;
  logic             pair_active_s;
  logic             pair_asc_s;
  logic [W-1:0]     word_i_s;
  logic [W-1:0]     word_l_s;
  logic             do_swap_s;

  // Strict less-than in the configured number format; equal words never swap.
  function automatic logic less_than(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED) begin
      return $signed(a) < $signed(b);
    end else begin
      return a < b;
    end
  endfunction

  assign partner_s     = i_q ^ j_q[LOG_N-1:0];
  assign pair_active_s = partner_s > i_q;
  // Only the lower index of each pair does the work; k bit of i selects the merge direction.
  assign pair_asc_s    = ((({1'b0, i_q} & k_q) == '0)) ^ dir_q;
  assign word_i_s      = mem_q[i_q];
  assign word_l_s      = mem_q[partner_s];
  assign do_swap_s     = pair_asc_s ? less_than(word_l_s, word_i_s)
                                    : less_than(word_i_s, word_l_s);

  // Next-state, datapath and registered-flag computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    i_d     = i_q;
    k_d     = k_q;
    j_d     = j_q;
    dir_d   = dir_q;
    mem_d   = mem_q;

    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          mem_d[idx_q] = bus.in_data;
          if (idx_q == '0) begin
            dir_d = bus.sort_desc;
          end else begin
            dir_d = dir_q;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = SORT;
          end else begin
            idx_d = idx_q + LOG_N'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end

      SORT: begin
        if (pair_active_s && do_swap_s) begin
          mem_d[i_q]       = word_l_s;
          mem_d[partner_s] = word_i_s;
        end else begin
          mem_d = mem_q;
        end
        // i sweeps every cycle; j halves per sweep; k doubles once j is exhausted.
        if (i_q == IDX_LAST) begin
          i_d = '0;
          if (j_q == KJ_ONE) begin
            if (k_q == K_MAX) begin
              k_d     = K_FIRST;
              j_d     = KJ_ONE;
              idx_d   = '0;
              state_d = DRAIN;
            end else begin
              k_d = k_q << 1;
              j_d = k_q;
            end
          end else begin
            j_d = j_q >> 1;
          end
        end else begin
          i_d = i_q + LOG_N'(1);
        end
      end

      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + LOG_N'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end

      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (idx_d == IDX_LAST);
    busy_d      = (state_d != LOAD);
  end

  // Control state and handshake flags; reset aborts any block in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      i_q         <= '0;
      k_q         <= K_FIRST;
      j_q         <= KJ_ONE;
      dir_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      i_q         <= i_d;
      k_q         <= k_d;
      j_q         <= j_d;
      dir_q       <= dir_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Block storage; contents are meaningless until a block has been loaded.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = mem_q[idx_q];
endmodule

// File: tb/tb_bitonic_sorter_seq.sv
// Bench: an unsigned and a signed sorter see identical stimulus; results are checked
// against fixed vectors and an array-sort reference model.
module tb_bitonic_sorter_seq;
  localparam int W = 8;
  localparam int LOG_N = 3;
  localparam int N = 8;
  localparam int SORT_CYCLES = 48;

  typedef logic [0:N-1][W-1:0] blk_t;
  typedef struct {
    blk_t din;
    logic desc;
    bit   toggle;
    blk_t exp_u;
    blk_t exp_s;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         sort_desc = 1'b0;
  logic         out_ready = 1'b0;

  bitonic_sorter_seq_if #(.W(W)) bu ();
  bitonic_sorter_seq_if #(.W(W)) bs ();

  assign bu.in_valid = in_valid;
  assign bu.in_data = in_data;
  assign bu.sort_desc = sort_desc;
  assign bu.out_ready = out_ready;
  assign bs.in_valid = in_valid;
  assign bs.in_data = in_data;
  assign bs.sort_desc = sort_desc;
  assign bs.out_ready = out_ready;

  bitonic_sorter_seq #(.W(W), .LOG_N(LOG_N), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bu.slave));
  bitonic_sorter_seq #(.W(W), .LOG_N(LOG_N), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic [W-1:0] got_u [N];
  logic [W-1:0] got_s [N];
  logic         got_last [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain insertion sort on an order key (sign bit flipped for signed mode).
  function automatic blk_t ref_sort(input blk_t d, input logic desc, input bit sgn);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    blk_t r;
    for (int x = 0; x < N; x++) a[x] = d[x];
    for (int x = 1; x < N; x++) begin
      for (int y = x; y > 0; y--) begin
        if ((sgn ? (a[y-1] ^ 8'h80) : a[y-1]) > (sgn ? (a[y] ^ 8'h80) : a[y])) begin
          t = a[y]; a[y] = a[y-1]; a[y-1] = t;
        end
      end
    end
    for (int x = 0; x < N; x++) r[x] = desc ? a[N-1-x] : a[x];
    return r;
  endfunction

  task automatic send_block(input blk_t din, input logic desc, input bit toggle, input bit gaps);
    int guard;
    for (int w = 0; w < N; w++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data = din[w];
      sort_desc = (w == 0) ? desc : (toggle ? ~desc : 1'($urandom_range(0, 1)));
      guard = 0;
      @(negedge clk);
      while (!bu.in_ready && guard < 300) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 300) begin
        compared++; mismatched++;
        $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1");
      end
      @(posedge clk); #1;
      if (w == N - 1) last_acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit check_lat);
    int guard = 0;
    int bad = 0;
    @(negedge clk);
    while (!bu.out_valid && guard < 300) begin
      if (bu.in_ready || bs.in_ready || !bu.busy) bad++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) begin
      compared++; mismatched++;
      $display("FAIL out_valid_timeout: out_valid stayed 0, expected 1");
    end
    chk("sort_flags", bad, 0);
    chk("signed_out_valid", bs.out_valid, 1'b1);
    if (check_lat) chk("latency", cyc - last_acc_cyc, SORT_CYCLES);
    @(posedge clk); #1;
  endtask

  task automatic recv(input int n, input bit rand_ready);
    int cnt = 0;
    int guard = 0;
    int bad = 0;
    bit stalled;
    logic [W:0] hold;
    while (cnt < n && guard < 2000) begin
      guard++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      @(negedge clk);
      if (bu.out_valid) begin
        if (bu.in_ready) bad++;
        if (out_ready) begin
          got_u[cnt] = bu.out_data;
          got_s[cnt] = bs.out_data;
          got_last[cnt] = bu.out_last;
          cnt++;
        end else begin
          stalled = 1'b1;
          hold = {bu.out_last, bu.out_data};
        end
      end
      @(posedge clk); #1;
      if (stalled) chk("stall_stable", {bu.out_last, bu.out_data}, hold);
    end
    if (cnt < n) begin
      compared++; mismatched++;
      $display("FAIL recv_timeout: got %0d words, expected %0d", cnt, n);
    end
    chk("no_input_while_busy", bad, 0);
    out_ready = 1'b0;
  endtask

  task automatic check_block(input blk_t exp_u, input blk_t exp_s);
    for (int w = 0; w < N; w++) begin
      chk($sformatf("u_word%0d", w), got_u[w], exp_u[w]);
      chk($sformatf("s_word%0d", w), got_s[w], exp_s[w]);
      chk($sformatf("last%0d", w), got_last[w], (w == N - 1) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit rnd);
    send_block(v.din, v.desc, v.toggle, rnd);
    wait_out(1'b1);
    recv(N, rnd);
    check_block(v.exp_u, v.exp_s);
    chk("in_ready_after_block", bu.in_ready, 1'b1);
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", bu.in_ready, 1'b1);
    chk("rst_out_valid", bu.out_valid, 1'b0);
    chk("rst_out_last", bu.out_last, 1'b0);
    chk("rst_busy", bu.busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [4];
  vec_t rv;

  initial begin
    vecs[0] = '{din: {8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4}, desc: 1'b0, toggle: 1'b0,
                exp_u: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
                exp_s: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}};
    vecs[1] = '{din: {8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4}, desc: 1'b1, toggle: 1'b1,
                exp_u: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                exp_s: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}};
    vecs[2] = '{din: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'h03, 8'h03, 8'h80, 8'h01}, desc: 1'b0, toggle: 1'b0,
                exp_u: {8'h00, 8'h00, 8'h01, 8'h03, 8'h03, 8'h80, 8'hFF, 8'hFF},
                exp_s: {8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h03, 8'h03}};
    vecs[3] = '{din: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'h03, 8'h03, 8'h80, 8'h01}, desc: 1'b1, toggle: 1'b1,
                exp_u: {8'hFF, 8'hFF, 8'h80, 8'h03, 8'h03, 8'h01, 8'h00, 8'h00},
                exp_s: {8'h03, 8'h03, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80}};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", bu.in_ready, 1'b1);
    chk("reset_out_valid", bu.out_valid, 1'b0);
    chk("reset_out_last", bu.out_last, 1'b0);
    chk("reset_busy", bu.busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) run_vec(vecs[v], 1'b0);

    // Reset in the middle of SORT, then a clean block.
    send_block(vecs[2].din, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_sort_busy", bu.busy, 1'b1);
    rst_pulse();
    run_vec(vecs[0], 1'b0);

    // Reset during DRAIN after three words, then a clean block.
    send_block(vecs[2].din, 1'b0, 1'b0, 1'b0);
    wait_out(1'b1);
    recv(3, 1'b0);
    chk("drain_partial_u2", got_u[2], 8'h01);
    rst_pulse();
    run_vec(vecs[1], 1'b0);

    // Random blocks with input gaps and random output back-pressure.
    for (int b = 0; b < 100; b++) begin
      for (int w = 0; w < N; w++) rv.din[w] = 8'($urandom);
      if (b % 4 == 0) rv.din[3] = rv.din[6];
      rv.desc = 1'($urandom_range(0, 1));
      rv.toggle = 1'b0;
      rv.exp_u = ref_sort(rv.din, rv.desc, 1'b0);
      rv.exp_s = ref_sort(rv.din, rv.desc, 1'b1);
      run_vec(rv, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bitonic_sorter_seq.md
# bitonic_sorter_seq

Sequential bitonic sorter: accepts a block of N = 2^LOG_N words over a valid/ready stream and sorts them in place with one compare-exchange unit. It returns the sorted block on a second valid/ready stream, with a last-word marker. It generalises the single comparator cell into a complete sort engine with:
- runtime sort direction
- a signed/unsigned compare mode
- handshaked I/O

It sits between a data producer and any consumer that needs ordered blocks.

## Interface
- W, 32, data word width in bits
- LOG_N, 3, log2 of block size; N = 2^LOG_N words per block (LOG_N >= 1)
- SIGNED, 0, 1 = compare as two's-complement; 0 = compare as unsigned
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  sorter accepts a word this cycle
- in_data  input  W  input word
- sort_desc  input  1  direction for the block; sampled only with the first word of a block (1 = largest first)
- out_valid  output  1  out_data holds a sorted word
- out_ready  input  1  consumer accepts a word this cycle
- out_data  output  W  sorted word
- out_last  output  1  high with the Nth (final) output word of a block
- busy  output  1  high in SORT and DRAIN

## Operation
- Storage: N x W register array mem[0..N-1], a 1-bit latched direction dir, and a state register.
- States: LOAD, SORT, DRAIN. Reset enters LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready, write mem[idx] = in_data and increment idx.
  - When idx = 0, also latch dir = sort_desc.
  - Accepting word idx = N-1 sets idx = 0 and moves to SORT.
- SORT:
  - Counters: k = 2, 4, ..., N (outer); j = k/2, ..., 1 (inner); i = 0..N-1 (one value per cycle).
  - Partner: l = i XOR j. If l > i, compare mem[i] and mem[l]; otherwise the cycle is idle.
  - Pair order:
    - Ascending pair if ((i AND k) == 0) XOR dir; descending pair otherwise.
    - For k = N, (i AND k) == 0 always holds, so the final order is ascending when dir = 0 and descending when dir = 1.
  - Compare-exchange:
    - Ascending pair: swap only if mem[i] > mem[l] strictly.
    - Descending pair: swap only if mem[i] < mem[l] strictly.
    - Equal values are never swapped.
  - Compare rule: signed if SIGNED = 1, else unsigned. No width growth and no arithmetic beyond the comparison.
  - Counter advance:
    - i wraps N-1 -> 0 and halves j.
    - When j would go below 1, double k and set j = k/2.
    - When k would exceed N, go to DRAIN with idx = 0.
- DRAIN:
  - out_valid = 1 and out_data = mem[idx].
  - out_last = 1 only when idx = N-1.
  - On out_valid & out_ready, increment idx.
  - Transfer of idx = N-1 sets idx = 0 and returns to LOAD.
- in_ready = 0 in SORT and DRAIN. out_valid = 0 in LOAD and SORT.

## Timing
- Reset values:
  - state = LOAD; idx, i, dir = 0; k = 2, j = 1.
  - in_ready = 1; out_valid, out_last, busy = 0; out_data = mem[0].
  - mem contents are don't-care.
- Reset asserted mid-operation (any state) aborts the block: partial input or sorted data is discarded, and the first word after reset is index 0 of a new block.
- Handshakes:
  - A transfer occurs on a rising edge with valid & ready both high.
  - out_data and out_last stay stable while out_valid & !out_ready.
  - in_ready and out_valid do not depend combinationally on in_valid or out_ready.
- Latency: let P = LOG_N*(LOG_N+1)/2 passes.
  - If the last input word is accepted at edge t, SORT occupies cycles t+1 .. t+P*N.
  - out_valid first rises after edge t+P*N. For N = 8 that is 48 SORT cycles.
- Throughput: one word per cycle on input and output when unstalled. One block every 2N + P*N cycles minimum.
- Stalls: in_valid low in LOAD and out_ready low in DRAIN stall only idx. SORT cannot stall.
- Boundary conditions:
  - sort_desc changing mid-block has no effect.
  - Back-to-back blocks: in_ready rises in the cycle after the final out_last transfer.

## Test plan
- W=8, LOG_N=3, SIGNED=0, sort_desc=0. Input 5,3,7,1,8,2,6,4 -> output 1,2,3,4,5,6,7,8. out_last only on 8. First out_valid exactly 48 cycles after the last input accept.
- Same data with sort_desc=1 on the first word, toggled to 0 mid-block -> output 8,7,6,5,4,3,2,1.
- Duplicates and extremes: 8'hFF,0,8'hFF,0,3,3,8'h80,1, unsigned ascending -> 0,0,1,3,3,8'h80,8'hFF,8'hFF.
- SIGNED=1, same input as the previous scenario, ascending -> 8'h80,8'hFF,8'hFF,0,0,1,3,3.
- Random out_ready (about 50% duty) and in_valid gaps over 100 random blocks -> every block matches a reference sort. out_data stable during stalls. No input accepted while busy.
- Assert rst for 1 cycle during SORT (cycle 20) and again during DRAIN after 3 outputs -> outputs drop to reset values asynchronously. The next full block sorts correctly, with no stale words emitted.
